// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Imported by serial_subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int calc_ndig(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int calc_cnt_w(input int ndig);
      return (ndig <= 1) ? 1 : $clog2(ndig);
   endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// DIGIT-bit ripple-borrow subtract slice: d = x - y - bi.
// Purely combinational; bo is the borrow out of the slice MSB.
module sub_digit_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bi,
   output logic [DIGIT-1:0] d,
   output logic             bo
);

   // ripple the borrow from bit 0 upward
   always_comb begin
      logic c;
      d = '0;
      c = bi;
      for (int i = 0; i < DIGIT; i++) begin
         d[i] = x[i] ^ y[i] ^ c;
         c    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
      end
      bo = c;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int CW   = calc_cnt_w(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             brw;
   logic [DIGIT-1:0] slice_d;
   logic             slice_bo;
   logic [WIDTH-1:0] diff_nx;
   logic             last;

   assign in_ready = (state == IDLE);
   assign last     = (cnt == LAST);

   sub_digit_slice #(
      .DIGIT(DIGIT)
   ) u_slice (
      .x (a_sh[DIGIT-1:0]),
      .y (b_sh[DIGIT-1:0]),
      .bi(brw),
      .d (slice_d),
      .bo(slice_bo)
   );

   // Completed low digits live in acc; the new digit enters at the top.
   if (NDIG > 1) begin : g_acc
      logic [WIDTH-DIGIT-1:0] acc;

      // shift finished digits down as each new one arrives
      always_ff @(posedge clk) begin
         if (rst)
            acc <= '0;
         else if (state == RUN)
            acc <= diff_nx[WIDTH-1:DIGIT];
      end

      assign diff_nx = {slice_d, acc};
   end else begin : g_one
      assign diff_nx = slice_d;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = RUN;
         RUN:  if (last) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // operand shifters, borrow chain, digit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         brw       <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh <= a;
                  b_sh <= b;
                  brw  <= bin;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh <= a_sh >> DIGIT;
               b_sh <= b_sh >> DIGIT;
               brw  <= slice_bo;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  diff      <= diff_nx;
                  bout      <= slice_bo;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef SUB_OVF_EN
   logic a_msb;
   logic b_msb;

   // sign bits captured at accept; overflow registered with the result
   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (state == RUN && last) begin
         ovf <= (a_msb != b_msb) && (diff_nx[WIDTH-1] != a_msb);
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (16/4 and 8/8 instances).
// Honours SUB_OVF_EN when defined.
module tb_serial_subtractor;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int N  = W / D;
   localparam int W8 = 8;

   logic clk = 1'b0;
   logic rst;

   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, diff;
   logic          bin, bout;
   logic          in_valid8, in_ready8, out_valid8, out_ready8;
   logic [W8-1:0] a8, b8, diff8;
   logic          bin8, bout8;
`ifdef SUB_OVF_EN
   logic ovf, ovf8;
`endif

   int compared   = 0;
   int mismatched = 0;

   logic [W-1:0] last_diff;
   logic         last_bout;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
      , .ovf(ovf)
`endif
   );

   serial_subtractor #(.WIDTH(W8), .DIGIT(W8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .bin(bin8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .diff(diff8), .bout(bout8)
`ifdef SUB_OVF_EN
      , .ovf(ovf8)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, wrapped to w bits.
   function automatic longint ref_sub(input longint x, input longint y,
                                      input longint bi);
      return x - y - bi;
   endfunction

   function automatic logic [W-1:0] wrap16(input longint r);
      return W'(r);
   endfunction

   function automatic logic [W8-1:0] wrap8(input longint r);
      return W8'(r);
   endfunction

   function automatic logic ovf_ref(input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    input logic bi);
      int r;
      r = int'($signed(x)) - int'($signed(y)) - int'(bi);
      return (r > 32767) || (r < -32768);
   endfunction

   task automatic run16(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input int hold);
      int k;
      longint r;
      logic [W-1:0] ed;
      logic eb;
      k = 0;
      while (!in_ready && k < 50) begin tick(); k++; end
      check("ready16", in_ready, 1);
      a = ta; b = tb; bin = tbin;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      tick();
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      k = 0;
      while (!out_valid && k < 50) begin tick(); k++; end
      check("lat16", k, N);
      r  = ref_sub(longint'(ta), longint'(tb), longint'(tbin));
      ed = wrap16(r);
      eb = (r < 0);
      check("diff16", diff, ed);
      check("bout16", bout, eb);
`ifdef SUB_OVF_EN
      check("ovf16", ovf, ovf_ref(ta, tb, tbin));
`endif
      last_diff = diff;
      last_bout = bout;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_diff", diff, ed);
         check("hold_bout", bout, eb);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      check("drain_valid", out_valid, 0);
      check("drain_ready", in_ready, 1);
   endtask

   task automatic run8(input logic [W8-1:0] ta, input logic [W8-1:0] tb,
                       input logic tbin);
      int k;
      longint r;
      a8 = ta; b8 = tb; bin8 = tbin;
      in_valid8 = 1'b1;
      out_ready8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      a8 = W8'($urandom); b8 = W8'($urandom);
      k = 0;
      while (!out_valid8 && k < 20) begin tick(); k++; end
      check("lat8", k, 1);
      r = ref_sub(longint'(ta), longint'(tb), longint'(tbin));
      check("diff8", diff8, wrap8(r));
      check("bout8", bout8, (r < 0));
      tick();
      check("drain8", out_valid8, 0);
      check("ready8", in_ready8, 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0;
      a8 = '0; b8 = '0; bin8 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
`ifdef SUB_OVF_EN
      check("rst_ovf", ovf, 0);
`endif

      run16(16'h1234, 16'h0234, 1'b0, 0);
      check("basic_const", last_diff, 16'h1000);
      run16(16'h0000, 16'h0001, 1'b0, 0);
      check("wrap_const", last_diff, 16'hFFFF);
      check("wrap_bout", last_bout, 1);
      run16(16'h0005, 16'h0003, 1'b1, 0);
      check("bin_const", last_diff, 16'h0001);
      run16(16'h0000, 16'h0000, 1'b1, 0);
      check("allones", last_diff, 16'hFFFF);
      run16(16'hA5A5, 16'h5A5A, 1'b0, 10);

      a = 16'hFFFF; b = 16'h0001; bin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", out_valid, 0);
      check("mid_diff", diff, 0);
      check("mid_bout", bout, 0);
      check("mid_ready", in_ready, 1);
      for (int i = 0; i < N + 2; i++) begin
         tick();
         check("mid_quiet", out_valid, 0);
      end
      run16(16'h4321, 16'h1111, 1'b1, 0);

`ifdef SUB_OVF_EN
      run16(16'h8000, 16'h0001, 1'b0, 0);
      check("ovf_dir", ovf, 1);
      run16(16'h7FFF, 16'h0001, 1'b0, 0);
      check("novf_dir", ovf, 0);
`endif

      for (int i = 0; i < 40; i++)
         run16(W'($urandom), W'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)));

      run8(8'h10, 8'h20, 1'b0);
      check("edge_const", diff8, 8'hF0);
      for (int i = 0; i < 20; i++)
         run8(W8'($urandom), W8'($urandom), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
